// File: rtl/led_pattern_sequencer.sv
// LED pattern player: plays a writable pattern memory onto the LED bank at a
// prescaled step rate. The player supports loop, one-shot, ping-pong and
// freeze modes.
module led_pattern_sequencer #(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int PRESCALE = 1000000,
    parameter int PRESC_W  = 20
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [WIDTH-1:0]  LEDS,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step_addr
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {M_LOOP, M_ONESHOT, M_PINGPONG, M_FREEZE} mode_e;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    logic [WIDTH-1:0]   mem [DEPTH];

    state_e             state_q;
    mode_e              mode_q;
    logic [ADDR_W-1:0]  last_q;
    logic [ADDR_W-1:0]  step_q, step_d;
    logic               dir_down_q, dir_down_d;
    logic [PRESC_W-1:0] presc_q;
    logic [WIDTH-1:0]   leds_q;
    logic               busy_q, done_q;
    logic               tick;
    logic               finish_d;

    // Pattern memory: synchronous write. It has no reset, so loaded
    // patterns survive RESET.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next step index and direction that apply when the prescaler ticks.
    always_comb begin
        tick       = (state_q == S_RUN) && (presc_q == PRESC_MAX);
        step_d     = step_q;
        dir_down_d = dir_down_q;
        finish_d   = 1'b0;
        unique case (mode_q)
            M_LOOP: begin
                step_d = (step_q == last_q) ? '0 : step_q + ADDR_W'(1);
            end
            M_ONESHOT: begin
                if (step_q == last_q) begin
                    finish_d = 1'b1;
                end else begin
                    step_d = step_q + ADDR_W'(1);
                end
            end
            M_PINGPONG: begin
                if (last_q == '0) begin
                    step_d = '0;
                end else if (!dir_down_q) begin
                    step_d = step_q + ADDR_W'(1);
                    if (step_d == last_q) begin
                        dir_down_d = 1'b1;
                    end
                end else begin
                    step_d = step_q - ADDR_W'(1);
                    if (step_d == '0) begin
                        dir_down_d = 1'b0;
                    end
                end
            end
            default: begin
                step_d = step_q;
            end
        endcase
    end

    // Player FSM with registered LED and status outputs. Start has priority
    // over stop. The LED read uses the pre-write memory contents.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            mode_q     <= M_LOOP;
            last_q     <= '0;
            step_q     <= '0;
            dir_down_q <= 1'b0;
            presc_q    <= '0;
            leds_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (start) begin
            state_q    <= S_RUN;
            mode_q     <= mode_e'(mode);
            last_q     <= last_addr;
            step_q     <= '0;
            dir_down_q <= 1'b0;
            presc_q    <= '0;
            leds_q     <= mem[0];
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else if (stop && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == S_RUN) begin
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                if (finish_d) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    step_q     <= step_d;
                    dir_down_q <= dir_down_d;
                    leds_q     <= mem[step_d];
                end
            end
        end
    end

    assign LEDS      = leds_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_addr = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer. The stimulus queues the
// expected output snapshots tagged with a cycle number. The monitor pops each
// snapshot and compares it at that cycle's falling edge.
module tb_led_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       start, stop;
    logic [1:0] mode;
    logic [2:0] last_addr;
    logic [4:0] LEDS;
    logic       busy, done;
    logic [2:0] step_addr;

    typedef struct {
        int unsigned cyc;
        int unsigned id;
        logic [4:0]  leds;
        logic [2:0]  step;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned exp_id = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    led_pattern_sequencer #(.PRESCALE(4)) dut (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stop(stop), .mode(mode),
        .last_addr(last_addr), .LEDS(LEDS), .busy(busy), .done(done),
        .step_addr(step_addr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input int unsigned id, input logic [4:0] l,
                         input logic [2:0] s, input logic b, input logic d);
        n_tests++;
        if ({LEDS, step_addr, busy, done} !== {l, s, b, d}) begin
            n_fail++;
            $display("FAIL chk%0d @cyc%0d: got LEDS=%b step=%0d busy=%b done=%b, want LEDS=%b step=%0d busy=%b done=%b",
                     id, cyc, LEDS, step_addr, busy, done, l, s, b, d);
        end
    endtask

    task automatic push(input int unsigned c, input logic [4:0] l,
                        input logic [2:0] s, input logic b, input logic d);
        exp_t e;
        e.cyc = c; e.id = exp_id; e.leds = l; e.step = s; e.busy = b; e.done = d;
        exp_id++;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic begin_start(input logic [1:0] md, input logic [2:0] la,
                               input logic with_stop, output int unsigned t);
        start = 1'b1; stop = with_stop; mode = md; last_addr = la;
        t = cyc;
    endtask

    task automatic end_pulse();
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
    endtask

    // Monitor: compare every queued snapshot that is due at this falling edge.
    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_tests++; n_fail++;
                $display("FAIL chk%0d missed: due cyc%0d, now cyc%0d", e.id, e.cyc, cyc);
            end else begin
                check(e.id, e.leds, e.step, e.busy, e.done);
            end
        end
    end

    initial begin
        int unsigned t, q;
        logic [4:0] pl [7];
        logic [2:0] sl [7];
        logic [4:0] pp [8];
        logic [2:0] sp [8];
        pl = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h01};
        sl = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        pp = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h04, 5'h02, 5'h01, 5'h02};
        sp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

        RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; mode = '0; last_addr = '0;

        // Reset state
        @(negedge CLK);
        push(cyc + 1, 5'h00, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        // Load memory: 1<<i for i<5, 1F above
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i);
            wr_data = (i < 5) ? 5'(1 << i) : 5'h1F;
            @(negedge CLK);
        end
        wr_en = 1'b0;

        // 1. Loop, last=5: each step appears and is still held 3 cycles later
        begin_start(2'd0, 3'd5, 1'b0, t);
        for (int k = 0; k < 7; k++) begin
            push(t + 1 + 4 * k, pl[k], sl[k], 1'b1, 1'b0);
            if (k < 6) push(t + 4 + 4 * k, pl[k], sl[k], 1'b1, 1'b0);
        end
        end_pulse();
        wait_until(t + 29);

        // 2. One-shot, last=2
        begin_start(2'd1, 3'd2, 1'b0, t);
        push(t + 1,  5'h01, 3'd0, 1'b1, 1'b0);
        push(t + 5,  5'h02, 3'd1, 1'b1, 1'b0);
        push(t + 9,  5'h04, 3'd2, 1'b1, 1'b0);
        push(t + 12, 5'h04, 3'd2, 1'b1, 1'b0);
        push(t + 13, 5'h04, 3'd2, 1'b0, 1'b1);
        push(t + 33, 5'h04, 3'd2, 1'b0, 1'b1);
        end_pulse();
        wait_until(t + 34);

        // 3a. Ping-pong, last=3 (restart out of DONE clears done)
        begin_start(2'd2, 3'd3, 1'b0, t);
        for (int k = 0; k < 8; k++) push(t + 1 + 4 * k, pp[k], sp[k], 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 30);

        // 3b. Ping-pong, last=0 stays at step 0
        begin_start(2'd2, 3'd0, 1'b0, t);
        for (int k = 0; k < 4; k++) push(t + 1 + 4 * k, 5'h01, 3'd0, 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 14);

        // 4. Stop at step 2, then start+stop together
        begin_start(2'd0, 3'd5, 1'b0, t);
        push(t + 9, 5'h04, 3'd2, 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 10);
        stop = 1'b1;
        push(t + 11, 5'h04, 3'd2, 1'b0, 1'b0);
        push(t + 21, 5'h04, 3'd2, 1'b0, 1'b0);
        @(negedge CLK);
        stop = 1'b0;
        wait_until(t + 22);
        begin_start(2'd0, 3'd5, 1'b1, t);
        push(t + 1, 5'h01, 3'd0, 1'b1, 1'b0);
        push(t + 5, 5'h02, 3'd1, 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 6);

        // 5. Freeze: a write shows only on the next tick, and a write on the tick edge reads old data
        begin_start(2'd3, 3'd0, 1'b0, t);
        push(t + 1,  5'h01, 3'd0, 1'b1, 1'b0);
        push(t + 3,  5'h01, 3'd0, 1'b1, 1'b0);
        push(t + 4,  5'h01, 3'd0, 1'b1, 1'b0);
        push(t + 5,  5'h0A, 3'd0, 1'b1, 1'b0);
        push(t + 9,  5'h0A, 3'd0, 1'b1, 1'b0);
        push(t + 12, 5'h0A, 3'd0, 1'b1, 1'b0);
        push(t + 13, 5'h15, 3'd0, 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 2);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h0A;
        wait_until(t + 3);
        wr_en = 1'b0;
        wait_until(t + 8);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h15;
        wait_until(t + 9);
        wr_en = 1'b0;
        wait_until(t + 14);

        // 6. Async reset mid-RUN; memory is retained afterwards
        begin_start(2'd0, 3'd5, 1'b0, t);
        push(t + 1, 5'h15, 3'd0, 1'b1, 1'b0);
        push(t + 5, 5'h02, 3'd1, 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 6);
        #2 RESET = 1'b1;
        #1 check(exp_id, 5'h00, 3'd0, 1'b0, 1'b0);
        exp_id++;
        @(negedge CLK);
        RESET = 1'b0;
        q = cyc;
        push(q + 1, 5'h00, 3'd0, 1'b0, 1'b0);
        push(q + 9, 5'h00, 3'd0, 1'b0, 1'b0);
        wait_until(q + 10);
        begin_start(2'd0, 3'd5, 1'b0, t);
        push(t + 1, 5'h15, 3'd0, 1'b1, 1'b0);
        push(t + 5, 5'h02, 3'd1, 1'b1, 1'b0);
        end_pulse();
        wait_until(t + 6);

        // Drain the scoreboard within a bounded time
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge CLK);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++; n_fail++;
            $display("FAIL chk%0d never compared: due cyc%0d", e.id, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised LED pattern player. Steps through a writable pattern memory at a programmable prescaled rate and drives the LED bank. Supports loop, one-shot, ping-pong and freeze modes, with start/stop control and status flags. Sits between the SOC clock/reset and the LEDS output pins; the processor or a bench loads patterns through a simple write port.

Parameters:
WIDTH, 5, LED/pattern width in bits
DEPTH, 8, pattern memory entries (power of two, >=2)
ADDR_W, 3, log2(DEPTH)
PRESCALE, 1000000, CLK cycles per pattern step (>=1)
PRESC_W, 20, prescaler counter width; must satisfy 2^PRESC_W >= PRESCALE

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
wr_en  in  1  pattern memory write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write pattern
start  in  1  one-cycle pulse; (re)starts playback at address 0
stop  in  1  one-cycle pulse; halts playback, LEDS hold
mode  in  2  0=loop, 1=one-shot, 2=ping-pong, 3=freeze; sampled only on start
last_addr  in  ADDR_W  final step index; sampled only on start
LEDS  out  WIDTH  registered pattern output
busy  out  1  high in RUN
done  out  1  high in DONE (one-shot completed)
step_addr  out  ADDR_W  index of the pattern currently on LEDS

Behaviour:
- RESET asserted (any time, async): state=IDLE, LEDS=0, busy=0, done=0, step_addr=0, prescaler=0, dir=up, latched mode=0, latched last=0. Memory contents are not cleared (no reset on the RAM).
- Memory: synchronous write on wr_en at any state. Read is read-before-write: a write to the address being loaded in the same cycle gives LEDS the old data; the new data appears the next time that address is loaded.
- States: IDLE, RUN, DONE.
- start (any state): next cycle state=RUN, busy=1, done=0, step_addr=0, LEDS=MEM[0], prescaler=0, dir=up; mode and last_addr are latched. start and stop in the same cycle: start wins.
- stop (RUN or DONE, no start): next cycle state=IDLE, busy=0, done=0, LEDS and step_addr hold. stop in IDLE: no effect.
- Prescaler: in RUN it counts 0..PRESCALE-1 and wraps; tick is asserted when count==PRESCALE-1. The first advance occurs PRESCALE cycles after the start cycle. The prescaler is frozen outside RUN.
- On tick in RUN, for next step p' from current p (L = latched last):
  - loop: p'= (p==L) ? 0 : p+1.
  - one-shot: if p==L, go to DONE (busy=0, done=1) and LEDS hold MEM[L]; else p'=p+1.
  - ping-pong: while up, p'=p+1 and dir flips to down at p'==L. While down, p'=p-1 and dir flips to up at p'==0. If L==0, p stays 0.
  - freeze: p unchanged; LEDS reload MEM[p] on each tick, so memory writes become visible.
- On each advance, step_addr<=p' and LEDS<=MEM[p'] in the same edge (step_addr always matches LEDS).
- L==0: loop and freeze show MEM[0] continuously. One-shot enters DONE on the first tick.
- In IDLE and DONE, outputs hold until start, stop or RESET.

Test Plan:
1. PRESCALE=4, DEPTH=8, MEM[i]=1<<i (i<5), MEM[5..7]=5'h1F, loop, last=5, start -> LEDS 00001,00010,00100,01000,10000,11111 then 00001; each step held 4 cycles; step_addr 0..5, 0; busy=1.
2. One-shot, last=2, start -> LEDS 00001,00010,00100 then DONE at the tick after step 2; done=1, busy=0, LEDS=00100 held for 20+ cycles.
3. Ping-pong, last=3 -> step_addr sequence 0,1,2,3,2,1,0,1; with last=0 -> step_addr stays 0.
4. Loop running; stop at step 2 -> LEDS=00100 frozen, busy=0. Then assert start and stop together -> RUN, LEDS=00001, step_addr=0.
5. Freeze at addr 0; write MEM[0]=5'h0A -> LEDS=01010 after the next tick, not before. Same-cycle write to the address being loaded -> LEDS shows the old value.
6. RESET pulsed mid-RUN between clock edges -> LEDS=0, busy=0, done=0 immediately (asynchronous). After release, no advance until start; MEM retained (start shows the previous MEM[0]).
